// File: rtl/sram_arbiter_pkg.sv
// Shared constants and types for the packet SRAM arbiter.
// Port ids match the parser/loader wiring at the SRAM boundary.
package sram_arbiter_pkg;
    localparam int ADDR_W           = 32;
    localparam int DATA_W           = 32;
    localparam int SEL_W            = 4;
    localparam int STAT_W           = 32;
    localparam int SRAM_PORT_PARSER = 0;
    localparam int SRAM_PORT_LOADER = 1;
    localparam logic [DATA_W-1:0] ZERO_WORD = '0;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] wdata;
    } sram_req_t;
endpackage

// File: rtl/sram_rsp_pipe.sv
// Owner-tag shift register: tracks which port issued each read so the
// response returning READ_LATENCY cycles after the SRAM access is routed back.
module sram_rsp_pipe #(
    parameter int READ_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic       i_port,
    output logic [1:0] o_rvalid
);
    logic [READ_LATENCY:0] r_vld_pipe;
    logic [READ_LATENCY:0] r_own_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_pipe <= '0;
            r_own_pipe <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[READ_LATENCY-1:0], i_push};
            r_own_pipe <= {r_own_pipe[READ_LATENCY-1:0], i_port};
        end
    end

    assign o_rvalid[0] = r_vld_pipe[READ_LATENCY] & ~r_own_pipe[READ_LATENCY];
    assign o_rvalid[1] = r_vld_pipe[READ_LATENCY] &  r_own_pipe[READ_LATENCY];
endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one registered SRAM port between parser (0) and loader (1).
// Optional per-port grant and conflict counters when SRAM_ARB_STATS_EN is defined.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int NUM_PORTS    = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_PORTS-1:0]                req_i,
    input  logic [NUM_PORTS-1:0]                we_i,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]    addr_i,
    input  logic [NUM_PORTS-1:0][SEL_W-1:0]     sel_i,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]    wdata_i,
    output logic [NUM_PORTS-1:0]                gnt_o,
    output logic [NUM_PORTS-1:0]                rvalid_o,
    output logic [NUM_PORTS-1:0][DATA_W-1:0]    rdata_o,
    output logic                                sram_ce_o,
    output logic                                sram_we_o,
    output logic [ADDR_W-1:0]                   sram_addr_o,
    output logic [SEL_W-1:0]                    sram_sel_o,
    output logic [DATA_W-1:0]                   sram_data_o,
    input  logic [DATA_W-1:0]                   sram_data_i
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [NUM_PORTS-1:0][STAT_W-1:0]    stat_gnt_o,
    output logic [STAT_W-1:0]                   stat_conflict_o
`endif
);
    logic      r_rr_ptr;
    logic      w_both;
    logic      w_any;
    logic      w_gnt_port;
    sram_req_t w_sel_req;

    assign w_both     = req_i[SRAM_PORT_PARSER] & req_i[SRAM_PORT_LOADER];
    assign w_any      = (|req_i) & ~rst;
    // A lone requester wins outright; the pointer only breaks ties.
    assign w_gnt_port = w_both ? r_rr_ptr : req_i[SRAM_PORT_LOADER];

    assign gnt_o[SRAM_PORT_PARSER] = w_any & ~w_gnt_port;
    assign gnt_o[SRAM_PORT_LOADER] = w_any &  w_gnt_port;

    assign w_sel_req = '{we:    we_i[w_gnt_port],
                         addr:  addr_i[w_gnt_port],
                         sel:   sel_i[w_gnt_port],
                         wdata: wdata_i[w_gnt_port]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= 1'b0;
            sram_ce_o   <= 1'b0;
            sram_we_o   <= 1'b0;
            sram_addr_o <= '0;
            sram_sel_o  <= '0;
            sram_data_o <= ZERO_WORD;
        end else if (w_any) begin
            r_rr_ptr    <= ~w_gnt_port;
            sram_ce_o   <= 1'b1;
            sram_we_o   <= w_sel_req.we;
            sram_addr_o <= w_sel_req.addr;
            sram_sel_o  <= w_sel_req.sel;
            sram_data_o <= w_sel_req.wdata;
        end else begin
            sram_ce_o   <= 1'b0;
            sram_we_o   <= 1'b0;
        end
    end

    sram_rsp_pipe #(.READ_LATENCY(READ_LATENCY)) u_rsp_pipe (
        .clk      (clk),
        .rst      (rst),
        .i_push   (w_any & ~w_sel_req.we),
        .i_port   (w_gnt_port),
        .o_rvalid (rvalid_o)
    );

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rdata
        assign rdata_o[p] = sram_data_i;
    end

`ifdef SRAM_ARB_STATS_EN
    logic [NUM_PORTS-1:0][STAT_W-1:0] r_stat_gnt;
    logic [STAT_W-1:0]                r_stat_conflict;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_gnt      <= '0;
            r_stat_conflict <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++)
                if (gnt_o[p]) r_stat_gnt[p] <= r_stat_gnt[p] + 32'd1;
            if (w_both) r_stat_conflict <= r_stat_conflict + 32'd1;
        end
    end

    assign stat_gnt_o      = r_stat_gnt;
    assign stat_conflict_o = r_stat_conflict;
`endif
endmodule
